kinase_ctrl_sequencer: RTL and testbench
========================================

KINASE_CTRL_SEQUENCER -- requirements
Module: kinase_ctrl_sequencer

Interface
REQ-001 SHALL have parameter STEP_DIV, default 4: clock cycles per actuation step, legal 1..65535.
REQ-002 SHALL have parameter PRIME_STEPS, default 6: steps spent in PRIME, legal 1..65535.
REQ-003 SHALL have parameter MIX_STEPS, default 12: steps spent in MIX, legal 1..65535.
REQ-004 SHALL have parameter INC_STEPS, default 8: steps spent in INCUBATE, legal 1..65535.
REQ-005 SHALL have parameter FLUSH_STEPS, default 4: steps spent in FLUSH, legal 1..65535.
REQ-006 SHALL have port clk, input, 1 bit: single clock for the whole block.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse on completion.
REQ-011 SHALL have port pad_ctrl_a, output, 13 bits: valve drive, 1 = pressurised.
REQ-012 SHALL have port pad_ctrl_s, output, 4 bits: selector valve drive.
REQ-013 SHALL have port pad_pump_a, output, 3 bits: three-phase peristaltic pump A drive.
REQ-014 SHALL have port pad_pump_b, output, 2 bits: two-phase pump B drive.

Function
REQ-015 SHALL use the states IDLE, PRIME, MIX, INCUBATE, FLUSH and DONE.
REQ-016 SHALL move from IDLE to PRIME on the edge after start=1 is sampled; start in any other state SHALL be ignored.
REQ-017 SHALL run a prescaler 0..STEP_DIV-1 that clears on every state entry and raises a tick when it equals STEP_DIV-1.
REQ-018 SHALL increment a step counter on each tick; it SHALL clear on every state entry.
REQ-019 SHALL leave PRIME, MIX, INCUBATE or FLUSH on the tick that completes that state's step count, giving exactly STEP_DIV*N cycles per state, where N is the state's step parameter.
REQ-020 SHALL follow the order PRIME -> MIX -> INCUBATE -> FLUSH -> DONE.
REQ-021 SHALL stay in DONE for exactly one cycle, with done=1, and then return to IDLE.
REQ-022 SHALL drive all outputs as Moore outputs decoded from the registered state and pump phase, with no combinational path from start to any output.
REQ-023 SHALL drive the following per-state values (pad_ctrl_a / pad_ctrl_s / pad_pump_a / pad_pump_b):
- IDLE and DONE: 0 / 0 / 0 / 0.
- PRIME: 13'h0007 / 4'b0001 / pump A sequence / 0.
- MIX: 13'h0038 / 4'b0010 / pump A sequence / 0.
- INCUBATE: 13'h1FFF / 4'b0100 / 0 / 0.
- FLUSH: 13'h01C0 / 4'b1000 / 0 / pump B sequence.
REQ-024 SHALL step the pump A sequence 101, 100, 110, 010, 011, 001 with wrap-around, advancing one entry per tick, starting at 101 when PRIME is entered and continuing without reset into MIX.
REQ-025 SHALL step the pump B sequence 10, 01 with wrap-around, advancing one entry per tick, starting at 10 when FLUSH is entered.
REQ-026 SHALL hold busy=1 from the cycle after start is accepted through the DONE cycle inclusive.
REQ-027 SHALL, with STEP_DIV=1, tick every cycle and SHALL still satisfy the state durations of REQ-019.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state IDLE, clear both counters and the pump phase, and drive busy=0, done=0 and every pad output to 0.
REQ-029 SHALL, on reset asserted mid-run, drop every valve and pump output to 0 without waiting for a clock.
REQ-030 SHALL, after rst_n deasserts, start no new run until start=1 is sampled.

Configuration
REQ-031 SHALL, when ABORT_EN (macro KINASE_SEQ_ABORT_EN) is defined, add a 1-bit input abort.
REQ-032 SHALL, with KINASE_SEQ_ABORT_EN defined and abort=1 sampled in PRIME, MIX or INCUBATE, enter FLUSH on the next edge with a fresh prescaler, step count and pump B phase, run the full flush, and then pass through DONE.
REQ-033 SHALL, with KINASE_SEQ_ABORT_EN defined, ignore abort in IDLE, FLUSH and DONE.
REQ-034 SHALL, without KINASE_SEQ_ABORT_EN defined, have no abort port and behave exactly as REQ-015..027.

Verification
REQ-035 SHALL cover: STEP_DIV=2, PRIME/MIX/INC/FLUSH=1/1/1/1, start pulse -> busy=1 for 9 cycles and a single done pulse 9 cycles after acceptance.
REQ-036 SHALL cover: default parameters, full run -> pad_pump_a visits 101,100,110,010,011,001,101... every 4 cycles, 18 transitions in total across PRIME+MIX.
REQ-037 SHALL cover: start held high for the whole run -> exactly one run, then a second run begins on the cycle after DONE.
REQ-038 SHALL cover: rst_n=0 asserted in MIX between clock edges -> all pad outputs 0 and busy=0 immediately, with no done pulse.
REQ-039 SHALL cover: KINASE_SEQ_ABORT_EN defined, abort in INCUBATE -> next state FLUSH, pad_pump_b=10, and done after FLUSH_STEPS*STEP_DIV+1 cycles.
REQ-040 SHALL cover: STEP_DIV=1, FLUSH_STEPS=3 -> pad_pump_b sequence 10, 01, 10, then 00 in DONE.

Source files
------------

// File: rtl/kinase_ctrl_sequencer.sv
// Fixed-order fluidic sequencer: PRIME -> MIX -> INCUBATE -> FLUSH -> DONE, driving valve and pump pads.
// Optional abort input is enabled by defining KINASE_SEQ_ABORT_EN.
module kinase_ctrl_sequencer #(
  parameter int unsigned STEP_DIV    = 4,
  parameter int unsigned PRIME_STEPS = 6,
  parameter int unsigned MIX_STEPS   = 12,
  parameter int unsigned INC_STEPS   = 8,
  parameter int unsigned FLUSH_STEPS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef KINASE_SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic [12:0] pad_ctrl_a,
  output logic [3:0]  pad_ctrl_s,
  output logic [2:0]  pad_pump_a,
  output logic [1:0]  pad_pump_b,
  output logic [2:0]  dbg_state
);

  // Handshake: start is a level request with no ready; a run is accepted on any edge
  // where start=1 while IDLE. done is a one-cycle pulse in DONE with no backpressure.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_MIX   = 3'd2,
    S_INC   = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [15:0] DIV_LAST   = 16'(STEP_DIV - 1);
  localparam logic [15:0] PRIME_LAST = 16'(PRIME_STEPS - 1);
  localparam logic [15:0] MIX_LAST   = 16'(MIX_STEPS - 1);
  localparam logic [15:0] INC_LAST   = 16'(INC_STEPS - 1);
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_STEPS - 1);

  state_t      state;
  state_t      state_after;
  logic [15:0] presc;
  logic [15:0] step_cnt;
  logic [15:0] step_last;
  logic [2:0]  pa_phase;
  logic        pb_phase;
  logic        tick;
  logic        abort_req;

  assign tick = (presc == DIV_LAST);

`ifdef KINASE_SEQ_ABORT_EN
  assign abort_req = abort && ((state == S_PRIME) || (state == S_MIX) || (state == S_INC));
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    step_last   = '0;
    state_after = S_IDLE;
    case (state)
      S_PRIME: begin
        step_last   = PRIME_LAST;
        state_after = S_MIX;
      end
      S_MIX: begin
        step_last   = MIX_LAST;
        state_after = S_INC;
      end
      S_INC: begin
        step_last   = INC_LAST;
        state_after = S_FLUSH;
      end
      S_FLUSH: begin
        step_last   = FLUSH_LAST;
        state_after = S_DONE;
      end
      default: begin
        step_last   = '0;
        state_after = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      presc    <= '0;
      step_cnt <= '0;
      pa_phase <= '0;
      pb_phase <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          presc    <= '0;
          step_cnt <= '0;
          if (start) begin
            state    <= S_PRIME;
            pa_phase <= '0;
          end
        end
        S_PRIME, S_MIX, S_INC, S_FLUSH: begin
          if (abort_req) begin
            state    <= S_FLUSH;
            presc    <= '0;
            step_cnt <= '0;
            pb_phase <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            // Pump A keeps its phase across the PRIME->MIX boundary.
            if ((state == S_PRIME) || (state == S_MIX)) begin
              pa_phase <= (pa_phase == 3'd5) ? 3'd0 : pa_phase + 3'd1;
            end
            if (state == S_FLUSH) begin
              pb_phase <= ~pb_phase;
            end
            if (step_cnt == step_last) begin
              state    <= state_after;
              step_cnt <= '0;
              if (state_after == S_FLUSH) begin
                pb_phase <= 1'b0;
              end
            end else begin
              step_cnt <= step_cnt + 16'd1;
            end
          end else begin
            presc <= presc + 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    pad_ctrl_a = '0;
    pad_ctrl_s = '0;
    pad_pump_a = '0;
    pad_pump_b = '0;
    case (state)
      S_PRIME, S_MIX: begin
        busy       = 1'b1;
        pad_ctrl_a = (state == S_PRIME) ? 13'h0007 : 13'h0038;
        pad_ctrl_s = (state == S_PRIME) ? 4'b0001 : 4'b0010;
        case (pa_phase)
          3'd0:    pad_pump_a = 3'b101;
          3'd1:    pad_pump_a = 3'b100;
          3'd2:    pad_pump_a = 3'b110;
          3'd3:    pad_pump_a = 3'b010;
          3'd4:    pad_pump_a = 3'b011;
          default: pad_pump_a = 3'b001;
        endcase
      end
      S_INC: begin
        busy       = 1'b1;
        pad_ctrl_a = 13'h1FFF;
        pad_ctrl_s = 4'b0100;
      end
      S_FLUSH: begin
        busy       = 1'b1;
        pad_ctrl_a = 13'h01C0;
        pad_ctrl_s = 4'b1000;
        pad_pump_b = pb_phase ? 2'b01 : 2'b10;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_kinase_ctrl_sequencer.sv
// Directed bench for kinase_ctrl_sequencer: three parameterisations sharing one clock and reset.
// Output vectors are packed {busy, done, pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b}.
module tb_kinase_ctrl_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_m, start_f, start_o;
`ifdef KINASE_SEQ_ABORT_EN
  logic abort_m;
`endif

  int checks   = 0;
  int failures = 0;

  logic        busy_m, done_m, busy_f, done_f, busy_o, done_o;
  logic [12:0] a_m, a_f, a_o;
  logic [3:0]  s_m, s_f, s_o;
  logic [2:0]  pa_m, pa_f, pa_o;
  logic [1:0]  pb_m, pb_f, pb_o;
  logic [2:0]  st_m, st_f, st_o;
  logic [23:0] obs_m, obs_f, obs_o;

  assign obs_m = {busy_m, done_m, a_m, s_m, pa_m, pb_m};
  assign obs_f = {busy_f, done_f, a_f, s_f, pa_f, pb_f};
  assign obs_o = {busy_o, done_o, a_o, s_o, pa_o, pb_o};

  kinase_ctrl_sequencer u_main (
    .clk(clk), .rst_n(rst_n), .start(start_m),
`ifdef KINASE_SEQ_ABORT_EN
    .abort(abort_m),
`endif
    .busy(busy_m), .done(done_m), .pad_ctrl_a(a_m), .pad_ctrl_s(s_m),
    .pad_pump_a(pa_m), .pad_pump_b(pb_m), .dbg_state(st_m)
  );

  kinase_ctrl_sequencer #(
    .STEP_DIV(2), .PRIME_STEPS(1), .MIX_STEPS(1), .INC_STEPS(1), .FLUSH_STEPS(1)
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_f),
`ifdef KINASE_SEQ_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy_f), .done(done_f), .pad_ctrl_a(a_f), .pad_ctrl_s(s_f),
    .pad_pump_a(pa_f), .pad_pump_b(pb_f), .dbg_state(st_f)
  );

  kinase_ctrl_sequencer #(
    .STEP_DIV(1), .PRIME_STEPS(1), .MIX_STEPS(1), .INC_STEPS(1), .FLUSH_STEPS(3)
  ) u_one (
    .clk(clk), .rst_n(rst_n), .start(start_o),
`ifdef KINASE_SEQ_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy_o), .done(done_o), .pad_ctrl_a(a_o), .pad_ctrl_s(s_o),
    .pad_pump_a(pa_o), .pad_pump_b(pb_o), .dbg_state(st_o)
  );

  function automatic logic [2:0] pump_a_at(int idx);
    case (idx % 6)
      0:       return 3'b101;
      1:       return 3'b100;
      2:       return 3'b110;
      3:       return 3'b010;
      4:       return 3'b011;
      default: return 3'b001;
    endcase
  endfunction

  // Expected outputs k cycles after the edge that accepted start (k=1 is the first PRIME cycle).
  function automatic logic [23:0] exp_out(int k, int d, int np, int nm, int ni, int nf);
    int t1, t2, t3, t4;
    logic [12:0] a;
    logic [3:0]  s;
    logic [2:0]  pa;
    logic [1:0]  pb;
    t1 = np * d;
    t2 = t1 + nm * d;
    t3 = t2 + ni * d;
    t4 = t3 + nf * d;
    a  = '0;
    s  = '0;
    pa = '0;
    pb = '0;
    if (k < 1 || k > t4 + 1) return 24'h0;
    if (k == t4 + 1) return {2'b11, 22'h0};
    if (k <= t1) begin
      a  = 13'h0007;
      s  = 4'b0001;
      pa = pump_a_at((k - 1) / d);
    end else if (k <= t2) begin
      a  = 13'h0038;
      s  = 4'b0010;
      pa = pump_a_at((k - 1) / d);
    end else if (k <= t3) begin
      a = 13'h1FFF;
      s = 4'b0100;
    end else begin
      a  = 13'h01C0;
      s  = 4'b1000;
      pb = ((((k - t3 - 1) / d) % 2) == 0) ? 2'b10 : 2'b01;
    end
    return {1'b1, 1'b0, a, s, pa, pb};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_m !== 24'h0 || st_m !== 3'd0) begin
      failures++;
      $display("FAIL reset_main got=%h/%0d exp=000000/0", obs_m, st_m);
    end
    checks++;
    if (obs_f !== 24'h0 || obs_o !== 24'h0) begin
      failures++;
      $display("FAIL reset_others got=%h/%h exp=000000/000000", obs_f, obs_o);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (obs_m !== 24'h0 || obs_f !== 24'h0 || obs_o !== 24'h0) begin
        failures++;
        $display("FAIL post_reset_idle k=%0d got=%h/%h/%h exp=all zero", k, obs_m, obs_f, obs_o);
      end
    end
  endtask

  task automatic test_fast_run();
    int busy_cnt, done_cnt, done_at;
    logic [23:0] e;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    @(negedge clk);
    start_f = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) start_f = 1'b0;
      e = exp_out(k, 2, 1, 1, 1, 1);
      checks++;
      if (obs_f !== e) begin
        failures++;
        $display("FAIL fast_run k=%0d got=%h exp=%h", k, obs_f, e);
      end
      if (busy_f === 1'b1) busy_cnt++;
      if (done_f === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
    end
    checks++;
    if (busy_cnt != 9) begin
      failures++;
      $display("FAIL fast_busy_cycles got=%0d exp=9", busy_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_at != 9) begin
      failures++;
      $display("FAIL fast_done_pulse got=%0d@%0d exp=1@9", done_cnt, done_at);
    end
  endtask

  task automatic test_step_div_one();
    logic [23:0] e;
    @(negedge clk);
    start_o = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) start_o = 1'b0;
      e = exp_out(k, 1, 1, 1, 1, 3);
      checks++;
      if (obs_o !== e) begin
        failures++;
        $display("FAIL div1_run k=%0d got=%h exp=%h", k, obs_o, e);
      end
      if (k == 7) begin
        checks++;
        if (pb_o !== 2'b00 || done_o !== 1'b1) begin
          failures++;
          $display("FAIL div1_done_pump_b got=%b/%b exp=00/1", pb_o, done_o);
        end
      end
    end
  endtask

  task automatic test_pump_a();
    logic [23:0] e;
    logic [2:0]  prev_pa;
    int          trans;
    trans = 0;
    @(negedge clk);
    start_m = 1'b1;
    prev_pa = pa_m;
    for (int k = 1; k <= 124; k++) begin
      @(negedge clk);
      if (k == 1) start_m = 1'b0;
      e = exp_out(k, 4, 6, 12, 8, 4);
      checks++;
      if (obs_m !== e) begin
        failures++;
        $display("FAIL full_run k=%0d got=%h exp=%h", k, obs_m, e);
      end
      if (k >= 2 && k <= 73 && pa_m !== prev_pa) trans++;
      prev_pa = pa_m;
    end
    checks++;
    if (trans != 18) begin
      failures++;
      $display("FAIL pump_a_transitions got=%0d exp=18", trans);
    end
  endtask

  task automatic test_start_held();
    logic [23:0] e;
    int          done_cnt;
    done_cnt = 0;
    @(negedge clk);
    start_m = 1'b1;
    for (int k = 1; k <= 126; k++) begin
      @(negedge clk);
      e = (k <= 122) ? exp_out(k, 4, 6, 12, 8, 4) : exp_out(k - 122, 4, 6, 12, 8, 4);
      checks++;
      if (obs_m !== e) begin
        failures++;
        $display("FAIL start_held k=%0d got=%h exp=%h", k, obs_m, e);
      end
      if (done_m === 1'b1) done_cnt++;
    end
    start_m = 1'b0;
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL start_held_done_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_midrun_reset();
    logic [23:0] e;
    do_reset();
    start_m = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) start_m = 1'b0;
    end
    e = exp_out(30, 4, 6, 12, 8, 4);
    checks++;
    if (obs_m !== e) begin
      failures++;
      $display("FAIL midrun_in_mix got=%h exp=%h", obs_m, e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_m !== 24'h0 || busy_m !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_immediate got=%h exp=000000", obs_m);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (obs_m !== 24'h0) begin
        failures++;
        $display("FAIL reset_held k=%0d got=%h exp=000000", k, obs_m);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (obs_m !== 24'h0 || done_m !== 1'b0) begin
        failures++;
        $display("FAIL after_reset_no_run k=%0d got=%h exp=000000", k, obs_m);
      end
    end
  endtask

`ifdef KINASE_SEQ_ABORT_EN
  task automatic test_abort();
    logic [23:0] e;
    do_reset();
    start_m = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) start_m = 1'b0;
      if (k <= 80) e = exp_out(k, 4, 6, 12, 8, 4);
      else if (k <= 96) e = {2'b10, 13'h01C0, 4'b1000, 3'b000,
                             ((((k - 81) / 4) % 2) == 0) ? 2'b10 : 2'b01};
      else if (k == 97) e = {2'b11, 22'h0};
      else e = 24'h0;
      checks++;
      if (obs_m !== e) begin
        failures++;
        $display("FAIL abort_run k=%0d got=%h exp=%h", k, obs_m, e);
      end
      if (k == 80) abort_m = 1'b1;
      if (k == 86) abort_m = 1'b0;
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start_m = 1'b0;
    start_f = 1'b0;
    start_o = 1'b0;
`ifdef KINASE_SEQ_ABORT_EN
    abort_m = 1'b0;
`endif
    test_reset();
    test_fast_run();
    test_step_div_one();
    test_pump_a();
    test_start_held();
    test_midrun_reset();
`ifdef KINASE_SEQ_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
